// File: rtl/wm_pkg.sv
// Washing-machine sequencer shared types: phase codes, default durations, widths.
`timescale 1ns/1ps
package wm_pkg;

  localparam int unsigned PERIOD_W = 4;
  localparam int unsigned PHASE_W  = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4,
    PH_DONE  = 3'd5,
    PH_PAUSE = 3'd6
  } phase_t;

  localparam logic [PERIOD_W-1:0] CLK_FREQ_DEF = 4'd5;
  localparam logic [PERIOD_W-1:0] FILL_T_DEF   = 4'd2;
  localparam logic [PERIOD_W-1:0] WASH_T_DEF   = 4'd5;
  localparam logic [PERIOD_W-1:0] RINSE_T_DEF  = 4'd3;
  localparam logic [PERIOD_W-1:0] SPIN_T_DEF   = 4'd4;

  // Phases that load and run the external timer.
  function automatic logic is_timed(input phase_t p);
    return (p == PH_FILL) || (p == PH_WASH) || (p == PH_RINSE) || (p == PH_SPIN);
  endfunction

  // Program order; SPIN finishes into DONE.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_FILL:  return PH_WASH;
      PH_WASH:  return PH_RINSE;
      PH_RINSE: return PH_SPIN;
      PH_SPIN:  return PH_DONE;
      default:  return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program sequencer IDLE->FILL->WASH->RINSE->SPIN->DONE.
// Drives a sibling phase timer (clear / enable / period / clk_freq) and consumes
// its done flag; drives valve, motor and pump. All outputs registered (Moore).
// Ports: clk, reset (async active-low), start, cancel, lid_closed, tmr_done in;
//   tmr_clear, tmr_enable, tmr_clk_freq[3:0], tmr_period[3:0], phase[2:0],
//   water_valve, motor_on, motor_fast, drain_pump, busy, cycle_done out.
// Option: WM_LID_PAUSE_EN adds a PAUSE phase (code 6) entered when the lid opens
//   during a RUN sub-step; the timer holds and the same phase resumes on close.
`timescale 1ns/1ps
module wash_cycle_ctrl
  import wm_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] CLK_FREQ = CLK_FREQ_DEF,
  parameter logic [PERIOD_W-1:0] FILL_T   = FILL_T_DEF,
  parameter logic [PERIOD_W-1:0] WASH_T   = WASH_T_DEF,
  parameter logic [PERIOD_W-1:0] RINSE_T  = RINSE_T_DEF,
  parameter logic [PERIOD_W-1:0] SPIN_T   = SPIN_T_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cancel,
  input  logic                lid_closed,
  input  logic                tmr_done,
  output logic                tmr_clear,
  output logic                tmr_enable,
  output logic [PERIOD_W-1:0] tmr_clk_freq,
  output logic [PERIOD_W-1:0] tmr_period,
  output logic [PHASE_W-1:0]  phase,
  output logic                water_valve,
  output logic                motor_on,
  output logic                motor_fast,
  output logic                drain_pump,
  output logic                busy,
  output logic                cycle_done
);

  // Zero durations would never complete; reject at elaboration.
  if (CLK_FREQ == '0) begin : g_bad_freq
    $error("wash_cycle_ctrl: CLK_FREQ must be nonzero");
  end
  if (FILL_T == '0 || WASH_T == '0 || RINSE_T == '0 || SPIN_T == '0) begin : g_bad_dur
    $error("wash_cycle_ctrl: phase durations must be nonzero");
  end

  function automatic logic [PERIOD_W-1:0] period_of(input phase_t p);
    case (p)
      PH_FILL:  return FILL_T;
      PH_WASH:  return WASH_T;
      PH_RINSE: return RINSE_T;
      PH_SPIN:  return SPIN_T;
      default:  return '0;
    endcase
  endfunction

  phase_t phase_q, phase_d;
  logic   run_q, run_d;       // 0 = LOAD sub-step, 1 = RUN sub-step
  logic   armed_q, armed_d;   // start must be seen low in IDLE before it triggers
  logic   abort;
  phase_t saved_d;
`ifdef WM_LID_PAUSE_EN
  phase_t saved_q;            // phase to resume after PAUSE
`endif

  logic                tmr_clear_q, tmr_clear_d;
  logic                tmr_enable_q, tmr_enable_d;
  logic [PERIOD_W-1:0] tmr_period_q, tmr_period_d;
  logic                water_valve_q, water_valve_d;
  logic                motor_on_q, motor_on_d;
  logic                motor_fast_q, motor_fast_d;
  logic                drain_pump_q, drain_pump_d;
  logic                busy_q, busy_d;
  logic                cycle_done_q, cycle_done_d;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q       <= PH_IDLE;
      run_q         <= 1'b0;
      armed_q       <= 1'b1;
`ifdef WM_LID_PAUSE_EN
      saved_q       <= PH_IDLE;
`endif
      tmr_clear_q   <= 1'b0;
      tmr_enable_q  <= 1'b0;
      tmr_period_q  <= '0;
      water_valve_q <= 1'b0;
      motor_on_q    <= 1'b0;
      motor_fast_q  <= 1'b0;
      drain_pump_q  <= 1'b0;
      busy_q        <= 1'b0;
      cycle_done_q  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      run_q         <= run_d;
      armed_q       <= armed_d;
`ifdef WM_LID_PAUSE_EN
      saved_q       <= saved_d;
`endif
      tmr_clear_q   <= tmr_clear_d;
      tmr_enable_q  <= tmr_enable_d;
      tmr_period_q  <= tmr_period_d;
      water_valve_q <= water_valve_d;
      motor_on_q    <= motor_on_d;
      motor_fast_q  <= motor_fast_d;
      drain_pump_q  <= drain_pump_d;
      busy_q        <= busy_d;
      cycle_done_q  <= cycle_done_d;
    end
  end

  // Next-state: cancel outranks timer done and lid events.
  always_comb begin
    phase_d = phase_q;
    run_d   = run_q;
    armed_d = armed_q;
`ifdef WM_LID_PAUSE_EN
    saved_d = saved_q;
`else
    saved_d = PH_IDLE;
`endif
    abort   = (phase_q != PH_IDLE) && cancel;
    if (abort) begin
      phase_d = PH_IDLE;
      run_d   = 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (!start) armed_d = 1'b1;
          if (start && lid_closed && armed_q) begin
            phase_d = PH_FILL;
            run_d   = 1'b0;
            armed_d = 1'b0;
          end
        end
        PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
          if (!run_q) begin
            run_d = 1'b1;
          end
`ifdef WM_LID_PAUSE_EN
          else if (!lid_closed) begin
            saved_d = phase_q;
            phase_d = PH_PAUSE;
          end
`endif
          else if (tmr_done) begin
            phase_d = next_phase(phase_q);
            run_d   = 1'b0;
          end
        end
        PH_DONE: phase_d = PH_IDLE;
`ifdef WM_LID_PAUSE_EN
        PH_PAUSE: begin
          if (lid_closed) begin
            phase_d = saved_q;
            run_d   = 1'b1;
          end
        end
`endif
        default: begin
          phase_d = PH_IDLE;
          run_d   = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so actuators switch with the phase.
  always_comb begin
    tmr_clear_d   = 1'b0;
    tmr_enable_d  = 1'b0;
    tmr_period_d  = '0;
    water_valve_d = 1'b0;
    motor_on_d    = 1'b0;
    motor_fast_d  = 1'b0;
    drain_pump_d  = 1'b0;
    busy_d        = (phase_d != PH_IDLE) && (phase_d != PH_DONE);
    cycle_done_d  = (phase_d == PH_DONE);
    if (is_timed(phase_d)) begin
      tmr_period_d = period_of(phase_d);
      tmr_clear_d  = !run_d;
      tmr_enable_d = run_d;
    end
    if (abort) tmr_clear_d = 1'b1;
    case (phase_d)
      PH_FILL:  water_valve_d = 1'b1;
      PH_WASH:  motor_on_d    = 1'b1;
      PH_RINSE: begin
        water_valve_d = 1'b1;
        motor_on_d    = 1'b1;
      end
      PH_SPIN: begin
        motor_on_d   = 1'b1;
        motor_fast_d = 1'b1;
        drain_pump_d = 1'b1;
      end
      PH_PAUSE: tmr_period_d = period_of(saved_d);
      default: ;
    endcase
  end

  assign tmr_clk_freq = CLK_FREQ;
  assign tmr_clear    = tmr_clear_q;
  assign tmr_enable   = tmr_enable_q;
  assign tmr_period   = tmr_period_q;
  assign phase        = phase_q;
  assign water_valve  = water_valve_q;
  assign motor_on     = motor_on_q;
  assign motor_fast   = motor_fast_q;
  assign drain_pump   = drain_pump_q;
  assign busy         = busy_q;
  assign cycle_done   = cycle_done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: vector table, directed corner sequences and a
// randomized run checked every cycle against a behavioural program model.
`timescale 1ns/1ps
module tb_wash_cycle_ctrl;

`ifdef WM_LID_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, cancel = 1'b0, lid_closed = 1'b0;
  logic       tmr_done;
  logic       tmr_clear, tmr_enable, water_valve, motor_on, motor_fast, drain_pump, busy, cycle_done;
  logic [3:0] tmr_clk_freq, tmr_period;
  logic [2:0] phase;

  logic use_stub = 1'b0, rnd_done = 1'b0;
  int   stub_cnt;
  logic stub_done;

  always #5 clk = ~clk;

  wash_cycle_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .lid_closed(lid_closed),
    .tmr_done(tmr_done), .tmr_clear(tmr_clear), .tmr_enable(tmr_enable),
    .tmr_clk_freq(tmr_clk_freq), .tmr_period(tmr_period), .phase(phase),
    .water_valve(water_valve), .motor_on(motor_on), .motor_fast(motor_fast),
    .drain_pump(drain_pump), .busy(busy), .cycle_done(cycle_done)
  );

  // Timer stub: counts enabled cycles, done after CLK_FREQ * period of them.
  always @(posedge clk or negedge reset) begin
    if (!reset)          stub_cnt <= 0;
    else if (tmr_clear)  stub_cnt <= 0;
    else if (tmr_enable) stub_cnt <= stub_cnt + 1;
  end
  assign stub_done = (tmr_period != 4'd0) && (stub_cnt >= 5 * int'(tmr_period));
  assign tmr_done  = use_stub ? stub_done : rnd_done;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural program model ----------------
  int dur_s[7]  = '{0, 2, 5, 3, 4, 0, 0};
  bit valve_t[7] = '{0, 1, 0, 1, 0, 0, 0};
  bit motor_t[7] = '{0, 0, 1, 1, 1, 0, 0};
  bit fast_t[7]  = '{0, 0, 0, 0, 1, 0, 0};

  int m_ph, m_saved;
  bit m_run, m_armed;
  bit e_clr, e_en, e_valve, e_motor, e_fast, e_pump, e_busy, e_done;
  int e_per;

  function automatic void model_reset();
    m_ph = 0; m_saved = 0; m_run = 0; m_armed = 1;
    e_clr = 0; e_en = 0; e_valve = 0; e_motor = 0; e_fast = 0; e_pump = 0;
    e_busy = 0; e_done = 0; e_per = 0;
  endfunction

  function automatic void model_step(input bit s, input bit c, input bit l, input bit d);
    bit ab, timed;
    ab = (m_ph != 0) && c;
    if (ab) begin
      m_ph = 0; m_run = 0;
    end else if (m_ph == 0) begin
      if (s && l && m_armed) begin m_ph = 1; m_run = 0; m_armed = 0; end
      else if (!s) m_armed = 1;
    end else if (m_ph >= 1 && m_ph <= 4) begin
      if (!m_run) m_run = 1;
      else if (PAUSE_EN && !l) begin m_saved = m_ph; m_ph = 6; end
      else if (d) begin m_ph = m_ph + 1; m_run = 0; end
    end else if (m_ph == 5) begin
      m_ph = 0;
    end else if (m_ph == 6) begin
      if (l) begin m_ph = m_saved; m_run = 1; end
    end
    timed   = (m_ph >= 1 && m_ph <= 4);
    e_clr   = ab || (timed && !m_run);
    e_en    = timed && m_run;
    e_per   = timed ? dur_s[m_ph] : (m_ph == 6 ? dur_s[m_saved] : 0);
    e_valve = valve_t[m_ph];
    e_motor = motor_t[m_ph];
    e_fast  = fast_t[m_ph];
    e_pump  = fast_t[m_ph];
    e_busy  = timed || (m_ph == 6);
    e_done  = (m_ph == 5);
  endfunction

  task automatic check_all();
    chk("phase", int'(phase), m_ph);
    chk("tmr_clear", int'(tmr_clear), int'(e_clr));
    chk("tmr_enable", int'(tmr_enable), int'(e_en));
    chk("tmr_period", int'(tmr_period), e_per);
    chk("water_valve", int'(water_valve), int'(e_valve));
    chk("motor_on", int'(motor_on), int'(e_motor));
    chk("motor_fast", int'(motor_fast), int'(e_fast));
    chk("drain_pump", int'(drain_pump), int'(e_pump));
    chk("busy", int'(busy), int'(e_busy));
    chk("cycle_done", int'(cycle_done), int'(e_done));
  endtask

  // One clock: sample inputs before the edge, step model, check at negedge.
  task automatic tick();
    bit s, c, l, d;
    #1;
    s = start; c = cancel; l = lid_closed; d = tmr_done;
    @(posedge clk);
    model_step(s, c, l, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_phase(input int p, input bit need_en, input int budget, input string nm);
    int n = 0;
    while (!(int'(phase) == p && (!need_en || tmr_enable)) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, (n < budget) ? 1 : 0, 1);
  endtask

  typedef struct {
    bit st, ca, lid, dn;
    int ph;
    bit clr, en, bsy;
    int per;
  } vec_t;
  vec_t vecs[14];

  initial begin
    int phq[$];
    int perq[$];
    int exp_ph[6] = '{1, 2, 3, 4, 5, 0};
    int exp_per[4] = '{2, 5, 3, 4};
    int n_done, n_clr, n;
    int last_ph;

    //          st ca lid dn  ph clr en bsy per
    vecs[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0,  0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 0,  1, 1, 0, 1, 2};
    vecs[4]  = '{0, 0, 1, 1,  1, 0, 1, 1, 2};
    vecs[5]  = '{0, 0, 1, 0,  1, 0, 1, 1, 2};
    vecs[6]  = '{0, 0, 1, 1,  2, 1, 0, 1, 5};
    vecs[7]  = '{0, 0, 1, 1,  2, 0, 1, 1, 5};
    vecs[8]  = '{0, 0, 1, 1,  3, 1, 0, 1, 3};
    vecs[9]  = '{0, 0, 1, 0,  3, 0, 1, 1, 3};
    vecs[10] = '{0, 1, 1, 1,  0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 0,  0, 0, 0, 0, 0};
    vecs[12] = '{1, 0, 1, 0,  1, 1, 0, 1, 2};
    vecs[13] = '{1, 1, 1, 0,  0, 1, 0, 0, 0};

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();
    chk("tmr_clk_freq", int'(tmr_clk_freq), 5);

    // Vector table: lid-gated start, LOAD ignoring done, cancel beating done in RINSE.
    for (int i = 0; i < 14; i++) begin
      start = vecs[i].st; cancel = vecs[i].ca; lid_closed = vecs[i].lid;
      rnd_done = vecs[i].dn; use_stub = 1'b0;
      tick();
      chk($sformatf("vec%0d_phase", i), int'(phase), vecs[i].ph);
      chk($sformatf("vec%0d_clear", i), int'(tmr_clear), int'(vecs[i].clr));
      chk($sformatf("vec%0d_enable", i), int'(tmr_enable), int'(vecs[i].en));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
      chk($sformatf("vec%0d_period", i), int'(tmr_period), vecs[i].per);
    end

    // Full program with timer stub; start held high afterwards.
    start = 1'b0; cancel = 1'b0; rnd_done = 1'b0; use_stub = 1'b1;
    tick();
    start = 1'b1;
    n_done = 0; n_clr = 0; n = 0; last_ph = 0;
    do begin
      tick();
      n++;
      if (int'(phase) != last_ph) phq.push_back(int'(phase));
      last_ph = int'(phase);
      if (tmr_clear && busy) perq.push_back(int'(tmr_period));
      if (tmr_clear) n_clr++;
      if (cycle_done) n_done++;
    end while (!(int'(phase) == 0 && phq.size() > 0) && n < 600);
    chk("prog_terminates", (n < 600) ? 1 : 0, 1);
    chk("prog_phase_count", phq.size(), 6);
    for (int i = 0; i < 6 && i < phq.size(); i++) chk($sformatf("prog_phase%0d", i), phq[i], exp_ph[i]);
    chk("prog_period_count", perq.size(), 4);
    for (int i = 0; i < 4 && i < perq.size(); i++) chk($sformatf("prog_period%0d", i), perq[i], exp_per[i]);
    chk("prog_cycle_done_pulses", n_done, 1);
    chk("prog_clear_pulses", n_clr, 4);

    // Start held through DONE must not retrigger.
    n = 0;
    repeat (20) begin tick(); if (busy) n++; end
    chk("no_retrigger", n, 0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("rearm_start", int'(phase), 1);

`ifdef WM_LID_PAUSE_EN
    // Lid opened during WASH RUN pauses without clearing the timer.
    wait_phase(2, 1'b1, 200, "pause_reach_wash");
    lid_closed = 1'b0;
    n_clr = 0;
    repeat (10) begin tick(); if (tmr_clear) n_clr++; end
    chk("pause_phase", int'(phase), 6);
    chk("pause_enable", int'(tmr_enable), 0);
    chk("pause_motor", int'(motor_on), 0);
    chk("pause_no_clear", n_clr, 0);
    lid_closed = 1'b1;
    tick();
    chk("resume_phase", int'(phase), 2);
    chk("resume_enable", int'(tmr_enable), 1);
    chk("resume_period", int'(tmr_period), 5);
`endif

    // Asynchronous reset in the middle of WASH.
    start = 1'b0;
    wait_phase(2, 1'b1, 200, "reset_reach_wash");
    tick();
    #2 reset = 1'b0;
    #1;
    chk("areset_phase", int'(phase), 0);
    chk("areset_motor", int'(motor_on), 0);
    chk("areset_enable", int'(tmr_enable), 0);
    chk("areset_period", int'(tmr_period), 0);
    chk("areset_busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) use_stub = ($urandom_range(0, 2) != 0);
      start      = ($urandom_range(0, 2) == 0);
      cancel     = ($urandom_range(0, 60) == 0);
      lid_closed = ($urandom_range(0, 15) != 0);
      rnd_done   = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
